// File: rtl/fifo_stream_reader.sv
// Turns a 1-cycle-latency FIFO pop interface into a valid/ready stream through
// a 2-entry skid buffer, and counts the words the consumer accepts.
module fifo_stream_reader #(
  parameter int DATA_WIDTH  = 256,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [DATA_WIDTH-1:0]  fifo_read_data,
  input  logic                   fifo_empty,
  output logic                   fifo_read_enable,
  input  logic                   flush,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COUNT_WIDTH-1:0] word_count
);

  // state    | meaning
  // ST_EMPTY | nothing buffered, out_valid low
  // ST_ONE   | entry0 holds the head word
  // ST_TWO   | entry0 is the head, entry1 the next word
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  state_t                 state_q, state_d;
  logic                   inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0]  entry0_q, entry0_d;
  logic [DATA_WIDTH-1:0]  entry1_q, entry1_d;
  logic [COUNT_WIDTH-1:0] word_count_q, word_count_d;

  logic       pop_raw;
  logic       pop;
  logic       push;
  logic [1:0] occ;
  logic [1:0] occ_after_pop;
  logic [1:0] occ_next;
  logic [2:0] pending;

  assign out_valid  = (state_q != ST_EMPTY);
  assign out_data   = entry0_q;
  assign word_count = word_count_q;

  always_comb begin
    occ           = state_q;
    pop_raw       = out_valid && out_ready;
    pop           = pop_raw && !flush;
    push          = inflight_q && !flush;
    // Words already owned (buffered or returning) after this cycle's pop.
    pending       = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop_raw};
    fifo_read_enable = reset_n && !fifo_empty && !flush && (pending < 3'd2);

    occ_after_pop = occ - {1'b0, pop};
    occ_next      = occ_after_pop + {1'b0, push};

    entry0_d = entry0_q;
    entry1_d = entry1_q;
    if (pop) begin
      entry0_d = entry1_q;
    end
    if (push) begin
      if (occ_after_pop == 2'd0) begin
        entry0_d = fifo_read_data;
      end else begin
        entry1_d = fifo_read_data;
      end
    end

    if (flush) begin
      state_d    = ST_EMPTY;
      inflight_d = 1'b0;
    end else begin
      state_d    = state_t'(occ_next);
      inflight_d = fifo_read_enable;
    end

    word_count_d = word_count_q;
    if (pop && (word_count_q != COUNT_MAX)) begin
      word_count_d = word_count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= ST_EMPTY;
      inflight_q   <= 1'b0;
      entry0_q     <= '0;
      entry1_q     <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      inflight_q   <= inflight_d;
      entry0_q     <= entry0_d;
      entry1_q     <= entry1_d;
      word_count_q <= word_count_d;
    end
  end

endmodule
